// File: rtl/seg7_scan_driver.sv
// Two-digit multiplexed 7-segment driver.
// Adds a dead cycle at the start of each digit slot, leading-zero blanking, blank and blink.
module seg7_scan_driver #(
  parameter int SCAN_DIV           = 1000,
  parameter int BLINK_FRAMES       = 64,
  parameter bit COMMON_ANODE       = 1'b0,
  parameter bit BLANK_LEADING_ZERO = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] bcd_tens,
  input  logic [3:0] bcd_units,
  input  logic       blank,
  input  logic       blink,
  output logic [6:0] seg,
  output logic [1:0] dig_en,
  output logic       frame_tick
);

  localparam int              CNT_W    = $clog2(SCAN_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);
  localparam int              FRM_W    = $clog2(BLINK_FRAMES + 1);
  localparam logic [FRM_W-1:0] FRM_LAST = FRM_W'(BLINK_FRAMES - 1);
  localparam logic [6:0]      SEG_OFF  = COMMON_ANODE ? 7'h7F : 7'h00;
  localparam logic [1:0]      DIG_OFF  = COMMON_ANODE ? 2'b11 : 2'b00;

  typedef enum logic {UNITS = 1'b0, TENS = 1'b1} slot_t;

  slot_t            slot;
  logic [CNT_W-1:0] cnt;
  logic [3:0]       sh_tens;
  logic [3:0]       sh_units;
  logic [FRM_W-1:0] frm_cnt;
  logic             blink_phase;

  logic             dead;
  logic             frame_end;
  logic             tens_dark;
  logic [6:0]       seg_nxt;
  logic [1:0]       dig_nxt;

  // Active-high segment pattern; codes above 9 show a dash.
  function automatic logic [6:0] decode(input logic [3:0] d);
    case (d)
      4'd0:    decode = 7'h3F;
      4'd1:    decode = 7'h06;
      4'd2:    decode = 7'h5B;
      4'd3:    decode = 7'h4F;
      4'd4:    decode = 7'h66;
      4'd5:    decode = 7'h6D;
      4'd6:    decode = 7'h7D;
      4'd7:    decode = 7'h07;
      4'd8:    decode = 7'h7F;
      4'd9:    decode = 7'h6F;
      default: decode = 7'h40;
    endcase
  endfunction

  always_comb begin
    // NOTE: every output of this block gets a default first, so no latch can be inferred.
    seg_nxt   = 7'h00;
    dig_nxt   = 2'b00;
    dead      = (cnt == '0);
    frame_end = (cnt == CNT_LAST) && (slot == TENS);
    tens_dark = BLANK_LEADING_ZERO && (sh_tens == 4'd0);
    if (!blank && !blink_phase && !dead) begin
      if (slot == UNITS) begin
        dig_nxt = 2'b01;
        seg_nxt = decode(sh_units);
      end else if (!tens_dark) begin
        dig_nxt = 2'b10;
        seg_nxt = decode(sh_tens);
      end
    end
  end

  // NOTE: all state here uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt         <= '0;
      slot        <= UNITS;
      sh_tens     <= 4'd0;
      sh_units    <= 4'd0;
      frm_cnt     <= '0;
      blink_phase <= 1'b0;
      seg         <= SEG_OFF;
      dig_en      <= DIG_OFF;
      frame_tick  <= 1'b0;
    end else begin
      if (cnt == CNT_LAST) begin
        cnt  <= '0;
        slot <= (slot == UNITS) ? TENS : UNITS;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end

      // Both digits are captured together so a frame never mixes two samples.
      if (dead && slot == UNITS) begin
        sh_tens  <= bcd_tens;
        sh_units <= bcd_units;
      end

      if (!blink) begin
        frm_cnt     <= '0;
        blink_phase <= 1'b0;
      end else if (frame_end) begin
        if (frm_cnt == FRM_LAST) begin
          frm_cnt     <= '0;
          blink_phase <= ~blink_phase;
        end else begin
          frm_cnt <= frm_cnt + FRM_W'(1);
        end
      end

      seg        <= seg_nxt ^ SEG_OFF;
      dig_en     <= dig_nxt ^ DIG_OFF;
      frame_tick <= frame_end;
    end
  end

endmodule
